encoder_poll_scheduler: RTL and testbench

Sequences a bank of NUM_ENC AEAT-6600 SSI encoder readers. It issues one position request at a time, round-robin, and handshakes each reader's ready/valid output. Captured positions go into a register bank read by the motor-control logic. It enforces a per-read timeout and a programmable sweep period, so control loops see fresh, time-bounded samples.

---
 rtl/encoder_poll_scheduler.sv | 148 ++++++++++++++
 tb/tb_encoder_poll_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_poll_scheduler.sv
// Round-robin poll scheduler for a bank of SSI encoder readers with per-read timeout and sweep period.
// Optional ENC_POLL_TIMEOUT_CNT_EN adds per-encoder saturating timeout counters on timeout_count.
module encoder_poll_scheduler #(
  parameter int NUM_ENC     = 4,
  parameter int RESOLUTION  = 10,
  parameter int TIMEOUT     = 4096,
  parameter int POLL_PERIOD = 50000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  output logic [NUM_ENC-1:0]              get_position,
  output logic [NUM_ENC-1:0]              data_out_ready,
  input  logic [NUM_ENC-1:0]              data_out_valid,
  input  logic [NUM_ENC*RESOLUTION-1:0]   enc_data,
  output logic [NUM_ENC*RESOLUTION-1:0]   pos_out,
  output logic [NUM_ENC-1:0]              pos_fresh,
  input  logic [NUM_ENC-1:0]              fresh_clr,
  output logic [NUM_ENC-1:0]              timeout_flag,
  output logic                            sweep_done,
  output logic                            busy,
  output logic [NUM_ENC*8-1:0]            timeout_count
);
  localparam int CNT_MAX = (TIMEOUT > POLL_PERIOD) ? TIMEOUT : POLL_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_ENC);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_PERIOD} state_t;

  state_t              state, nstate;
  logic [IW-1:0]       idx, nidx;
  logic [CW-1:0]       cnt, ncnt;
  logic [NUM_ENC-1:0]  gp_n, rdy_n, sel;
  logic                sd_n, busy_n, hit, expire, cap, tmo;

  assign hit    = data_out_valid[idx];
  assign expire = (cnt == CW'(TIMEOUT - 1));
  assign cap    = (state == S_WAIT) && hit;
  assign tmo    = (state == S_WAIT) && !hit && expire;
  assign sel    = NUM_ENC'(1) << idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    nidx   = idx;
    ncnt   = cnt;
    case (state)
      S_IDLE: if (enable) begin
        nstate = S_REQ;
        nidx   = '0;
      end
      S_REQ: begin
        ncnt   = '0;
        nstate = S_WAIT;
      end
      // valid on the last timeout cycle still counts as a capture
      S_WAIT: if (hit || expire) nstate = S_NEXT;
              else               ncnt   = cnt + CW'(1);
      S_NEXT: if (idx == IW'(NUM_ENC - 1)) begin
        nidx = '0;
        if (enable) begin
          nstate = S_PERIOD;
          ncnt   = CW'(POLL_PERIOD - 1);
        end else begin
          nstate = S_IDLE;
        end
      end else if (enable) begin
        nidx   = idx + IW'(1);
        nstate = S_REQ;
      end else begin
        nidx   = '0;
        nstate = S_IDLE;
      end
      S_PERIOD: if (!enable)       nstate = S_IDLE;
                else if (cnt == '0) nstate = S_REQ;
                else               ncnt   = cnt - CW'(1);
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    gp_n   = '0;
    rdy_n  = '0;
    if (nstate == S_REQ)  gp_n[nidx]  = 1'b1;
    if (nstate == S_WAIT) rdy_n[nidx] = 1'b1;
    sd_n   = (nstate == S_NEXT) && (nidx == IW'(NUM_ENC - 1));
    busy_n = (nstate != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      get_position   <= '0;
      data_out_ready <= '0;
      sweep_done     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      get_position   <= gp_n;
      data_out_ready <= rdy_n;
      sweep_done     <= sd_n;
      busy           <= busy_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_out      <= '0;
      pos_fresh    <= '0;
      timeout_flag <= '0;
    end else begin
      pos_fresh <= (pos_fresh & ~fresh_clr) | (cap ? sel : '0);
      if (cap) begin
        pos_out[idx*RESOLUTION +: RESOLUTION] <= enc_data[idx*RESOLUTION +: RESOLUTION];
        timeout_flag[idx] <= 1'b0;
      end
      if (tmo) timeout_flag[idx] <= 1'b1;
    end
  end

`ifdef ENC_POLL_TIMEOUT_CNT_EN
  logic [NUM_ENC-1:0][7:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else begin
      for (int i = 0; i < NUM_ENC; i++)
        if (tmo && sel[i] && tcnt[i] != 8'hFF) tcnt[i] <= tcnt[i] + 8'd1;
    end
  end

  assign timeout_count = tcnt;
`else
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_encoder_poll_scheduler.sv
// Bench for encoder_poll_scheduler: reader models with per-transaction latency, transaction-level reference model.
module tb_encoder_poll_scheduler;
  localparam int N  = 4;
  localparam int R  = 10;
  localparam int TO = 16;
  localparam int PP = 100;

  logic           clk = 1'b0;
  logic           rst_n, enable;
  logic [N-1:0]   get_position, data_out_ready, data_out_valid, pos_fresh, fresh_clr, timeout_flag;
  logic [N*R-1:0] enc_data, pos_out;
  logic           sweep_done, busy;
  logic [N*8-1:0] timeout_count;

  encoder_poll_scheduler #(.NUM_ENC(N), .RESOLUTION(R), .TIMEOUT(TO), .POLL_PERIOD(PP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .get_position(get_position), .data_out_ready(data_out_ready),
    .data_out_valid(data_out_valid), .enc_data(enc_data),
    .pos_out(pos_out), .pos_fresh(pos_fresh), .fresh_clr(fresh_clr),
    .timeout_flag(timeout_flag), .sweep_done(sweep_done), .busy(busy),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // reader stimulus knobs: latency < 0 means random per transaction, >= TO means never answers
  int           lat_cfg[N], cur_lat[N], rcnt[N], dur[N], tc_m[N];
  logic [R-1:0] fix_val[N], cap_val[N], pos_m[N];
  bit           data_fix, stray, clr_rand, clr_all, clr_on_cap0, en, gap_on;
  logic [N-1:0] flag_m, fresh_m, prev_rdy, prev_gp, clr_prev;
  int           exp_idx, sweeps, gap, idle_ticks, gp_seen;
  int           n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      pos_m[i] = '0; tc_m[i] = 0; rcnt[i] = 0; dur[i] = 0;
    end
    fresh_m = '0; flag_m = '0; prev_rdy = '0; prev_gp = '0; clr_prev = '0;
    exp_idx = 0; gap_on = 0; gap = 0; idle_ticks = 0;
  endtask

  task automatic monitor();
    logic [N-1:0]   cap_set, one;
    logic [N*R-1:0] pe;
    logic [N*8-1:0] te;
    bit             comp_last;
    cap_set = '0; comp_last = 0; one = 1;
    for (int i = 0; i < N; i++) begin
      if (data_out_ready[i]) dur[i] = prev_rdy[i] ? dur[i] + 1 : 1;
      if (prev_rdy[i] && !data_out_ready[i]) begin
        if (cur_lat[i] < TO) begin
          chk("capture_len", dur[i], cur_lat[i] + 1);
          pos_m[i] = cap_val[i]; cap_set[i] = 1'b1; flag_m[i] = 1'b0;
        end else begin
          chk("timeout_len", dur[i], TO);
          flag_m[i] = 1'b1;
          if (tc_m[i] < 255) tc_m[i]++;
        end
        if (i == N - 1) begin comp_last = 1; sweeps++; end
        exp_idx = (en && i != N - 1) ? i + 1 : 0;
      end
    end
    fresh_m = (fresh_m & ~clr_prev) | cap_set;
    if (gap_on) gap++;
    if (!en) gap_on = 0;
    if ((data_out_ready & ~prev_rdy) != '0) chk("ready_after_req", data_out_ready, prev_gp);
    if (get_position != '0) begin
      gp_seen++;
      chk("req_idx", get_position, one << exp_idx);
      // PERIOD idles POLL_PERIOD cycles, so REQ lands POLL_PERIOD+1 cycles after the sweep_done cycle
      if (gap_on) begin chk("period_gap", gap, PP + 1); gap_on = 0; end
    end
    chk("sweep_done", sweep_done, comp_last);
    if (comp_last && en) begin gap_on = 1; gap = 0; end
    if ((get_position | data_out_ready) != '0 || sweep_done) chk("busy_active", busy, 1);
    for (int i = 0; i < N; i++) begin
      pe[i*R +: R] = pos_m[i];
`ifdef ENC_POLL_TIMEOUT_CNT_EN
      te[i*8 +: 8] = 8'(tc_m[i]);
`else
      te[i*8 +: 8] = 8'd0;
`endif
    end
    chk("pos_out", pos_out, pe);
    chk("pos_fresh", pos_fresh, fresh_m);
    chk("timeout_flag", timeout_flag, flag_m);
    chk("timeout_count", timeout_count, te);
    if ((get_position | data_out_ready) != '0 || sweep_done || !en) idle_ticks = 0;
    else idle_ticks++;
    n_chk++;
    assert (idle_ticks <= PP + 20) else begin
      n_fail++;
      $error("FAIL stall: observed %0d idle cycles expected at most %0d", idle_ticks, PP + 20);
      idle_ticks = 0;
    end
    prev_rdy = data_out_ready;
    prev_gp  = get_position;
  endtask

  task automatic drive();
    logic [N*R-1:0] d;
    logic [N-1:0]   v, c;
    v = '0; c = '0;
    for (int i = 0; i < N; i++) begin
      d[i*R +: R] = data_fix ? fix_val[i] : R'($urandom_range(0, (1 << R) - 1));
      if (data_out_ready[i]) begin
        if (rcnt[i] == 0) cur_lat[i] = (lat_cfg[i] < 0) ? int'($urandom_range(0, 20)) : lat_cfg[i];
        if (rcnt[i] == cur_lat[i]) begin
          v[i] = 1'b1;
          cap_val[i] = d[i*R +: R];
          if (clr_on_cap0 && i == 0) c[0] = 1'b1;
        end
        rcnt[i]++;
      end else begin
        rcnt[i] = 0;
        if (stray && $urandom_range(0, 3) == 0) v[i] = 1'b1;
      end
      if (clr_all || (clr_rand && $urandom_range(0, 7) == 0)) c[i] = 1'b1;
    end
    clr_prev = c; fresh_clr = c; data_out_valid = v; enc_data = d; enable = en;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rst_n) monitor();
    drive();
  endtask

  task automatic wait_sweeps(input int n, input int budget);
    int target, k;
    target = sweeps + n; k = 0;
    while (sweeps < target && k < budget) begin tick(); k++; end
    chk("sweep_reached", sweeps >= target, 1);
  endtask

  task automatic wait_rdy(input int i, input int budget);
    int k;
    k = 0;
    while (!data_out_ready[i] && k < budget) begin tick(); k++; end
    chk("ready_reached", data_out_ready[i], 1);
  endtask

  initial begin
    int           k, gp0;
    logic [N*R-1:0] pv;
    n_chk = 0; n_fail = 0; sweeps = 0; gp_seen = 0;
    rst_n = 1'b0; en = 0; enable = 1'b0;
    data_out_valid = '0; fresh_clr = '0; enc_data = '0;
    stray = 0; clr_rand = 0; clr_all = 0; clr_on_cap0 = 0; data_fix = 1;
    fix_val[0] = 10'h001; fix_val[1] = 10'h0AB; fix_val[2] = 10'h2FF; fix_val[3] = 10'h3FF;
    for (int i = 0; i < N; i++) begin lat_cfg[i] = 5; cur_lat[i] = 0; cap_val[i] = '0; end
    reset_model();

    // reset state
    #3;
    chk("reset_ctl", {get_position, data_out_ready, sweep_done, busy, pos_fresh, timeout_flag}, '0);
    chk("reset_pos", pos_out, '0);
    chk("reset_tcnt", timeout_count, '0);
    #10 rst_n = 1'b1;

    // basic sweep, all readers answer 5 cycles after ready
    en = 1;
    wait_sweeps(1, 2000);
    pv = {10'h3FF, 10'h2FF, 10'h0AB, 10'h001};
    chk("basic_pos", pos_out, pv);
    chk("basic_fresh", pos_fresh, 4'b1111);

    // encoder 2 silent: timeout, prior value held, encoder 3 still polled
    lat_cfg[2] = 99;
    wait_sweeps(1, 2000);
    chk("tmo_flag", timeout_flag, 4'b0100);
    chk("tmo_hold", pos_out[2*R +: R], 10'h2FF);
    chk("tmo_next_enc", pos_out[3*R +: R], 10'h3FF);

    // later good read clears the flag
    lat_cfg[2] = 5; fix_val[2] = 10'h123;
    wait_sweeps(1, 2000);
    chk("tmo_clear", timeout_flag, 4'b0000);
    chk("tmo_recap", pos_out[2*R +: R], 10'h123);

    // valid on the final timeout cycle wins
    lat_cfg[1] = TO - 1; fix_val[1] = 10'h155;
    wait_sweeps(1, 2000);
    chk("late_valid_pos", pos_out[1*R +: R], 10'h155);
    chk("late_valid_flag", timeout_flag[1], 1'b0);

    // stray valids on unselected encoders and outside WAIT
    lat_cfg[1] = 5; stray = 1;
    wait_sweeps(2, 4000);
    chk("stray_pos0", pos_out[R-1:0], 10'h001);

    // clear all fresh bits, then clear bit 0 on the very capture cycle
    clr_all = 1; tick(); tick(); tick(); clr_all = 0; tick();
    chk("fresh_cleared", pos_fresh, 4'b0000);
    clr_on_cap0 = 1;
    wait_sweeps(1, 2000);
    clr_on_cap0 = 0;
    chk("fresh_set_wins", pos_fresh, 4'b1111);

    // randomized latencies, data, clears and strays
    data_fix = 0; clr_rand = 1;
    for (int i = 0; i < N; i++) lat_cfg[i] = -1;
    repeat (3000) tick();
    clr_rand = 0;

    // enable drop while waiting on encoder 1
    for (int i = 0; i < N; i++) lat_cfg[i] = 3;
    wait_rdy(1, 400);
    en = 0;
    k = 0;
    while (data_out_ready != '0 && k < TO + 5) begin tick(); k++; end
    gp0 = gp_seen;
    repeat (20) tick();
    chk("drop_busy", busy, 1'b0);
    chk("drop_no_req", gp_seen - gp0, 0);
    chk("drop_ready", data_out_ready, '0);
    en = 1;

    // reset mid-WAIT
    wait_rdy(2, 400);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {get_position, data_out_ready, sweep_done, busy, pos_fresh, timeout_flag}, '0);
    chk("midrst_pos", pos_out, '0);
    chk("midrst_tcnt", timeout_count, '0);
    reset_model();
    #2 rst_n = 1'b1;
    wait_sweeps(1, 2000);

    // saturation of the timeout counter on encoder 3
    stray = 0;
    lat_cfg[0] = 0; lat_cfg[1] = 0; lat_cfg[2] = 0; lat_cfg[3] = 99;
    wait_sweeps(300, 300 * 200);
`ifdef ENC_POLL_TIMEOUT_CNT_EN
    chk("tcnt_saturate", timeout_count[3*8 +: 8], 8'd255);
`else
    chk("tcnt_absent", timeout_count[3*8 +: 8], 8'd0);
`endif
    chk("sat_flag", timeout_flag, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
